i2c_target_regport: RTL and testbench

//  I2C target (responder) for the 16-bit-register-address protocol our i2c transmitter drives:

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_line_filter.sv | 31 +++
 rtl/i2c_target_regport.sv | 195 +++++++++++++++++++
 tb/tb_i2c_target_regport.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants.
// Also used by the I2C transmitter.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    ACK_DEV,
    REG_HI,
    ACK_HI,
    REG_LO,
    ACK_LO,
    WR_DATA,
    ACK_WR,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NAK      = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a hold filter: the output follows the
// input only after FILTER_LEN consecutive equal synchronized samples.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic filtered
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;

  // Reset to 1 so an idle bus never produces a spurious edge at release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= 2'b11;
      hist     <= '1;
      filtered <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      hist <= {hist[FILTER_LEN-2:0], sync[1]};
      if (&hist)
        filtered <= 1'b1;
      else if (~|hist)
        filtered <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_target_regport.sv
// I2C target with a 16-bit register pointer: bus writes become a one-cycle
// write strobe, bus reads are served from an external register read port.
//
// state    | meaning
// IDLE     | bus free or not addressed, SDA released
// DEV_ADDR | shifting in {device address, R/W}
// ACK_DEV  | driving ACK for matched device address
// REG_HI   | shifting in pointer[15:8]
// ACK_HI   | driving ACK for pointer high byte
// REG_LO   | shifting in pointer[7:0]
// ACK_LO   | driving ACK for pointer low byte
// WR_DATA  | shifting in a write data byte
// ACK_WR   | driving ACK for write data byte
// RD_DATA  | driving read data bits 7..0
// RD_ACK   | SDA released, sampling controller ACK/NAK
// IGNORE   | not addressed or read ended, wait for START/STOP
module i2c_target_regport
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ID     = 7'h35,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scl_i,
  inout  wire         sda_io,
  output logic        wr_en_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i,
  output logic        busy_o
);

  i2c_tgt_state_t state;
  logic        scl_f, sda_f, scl_prev, sda_prev;
  logic        sda_low;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic [15:0] pointer;
  logic        rw;
  logic        ack_seen;
  logic        scl_rise, scl_fall, start_det, stop_det;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clock    (clock),
    .reset_n  (reset_n),
    .raw      (scl_i),
    .filtered (scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clock    (clock),
    .reset_n  (reset_n),
    .raw      (sda_io),
    .filtered (sda_f)
  );

  assign sda_io    = sda_low ? 1'b0 : 1'bz;
  assign rd_addr_o = pointer;

  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      sda_low   <= 1'b0;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      pointer   <= 16'h0000;
      rw        <= I2C_RW_WRITE;
      ack_seen  <= 1'b0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= 16'h0000;
      wr_data_o <= 8'h00;
      busy_o    <= 1'b0;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
      wr_en_o  <= 1'b0;
      if (start_det) begin
        state   <= DEV_ADDR;
        bit_cnt <= 4'd0;
        sda_low <= 1'b0;
        busy_o  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        sda_low <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR, REG_HI, REG_LO, WR_DATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              case (state)
                DEV_ADDR: begin
                  if (shift[7:1] == DEV_ID) begin
                    sda_low <= 1'b1;
                    busy_o  <= 1'b1;
                    rw      <= shift[0];
                    state   <= ACK_DEV;
                  end else begin
                    state <= IGNORE;
                  end
                end
                REG_HI: begin
                  pointer[15:8] <= shift;
                  sda_low       <= 1'b1;
                  state         <= ACK_HI;
                end
                REG_LO: begin
                  pointer[7:0] <= shift;
                  sda_low      <= 1'b1;
                  state        <= ACK_LO;
                end
                default: begin
                  wr_data_o <= shift;
                  wr_addr_o <= pointer;
                  wr_en_o   <= 1'b1;
                  pointer   <= pointer + 16'd1;
                  sda_low   <= 1'b1;
                  state     <= ACK_WR;
                end
              endcase
            end
          end
          ACK_DEV: begin
            if (scl_fall) begin
              if (rw == I2C_RW_READ) begin
                shift   <= rd_data_i;
                sda_low <= ~rd_data_i[7];
                state   <= RD_DATA;
              end else begin
                sda_low <= 1'b0;
                state   <= REG_HI;
              end
            end
          end
          ACK_HI: begin
            if (scl_fall) begin
              sda_low <= 1'b0;
              state   <= REG_LO;
            end
          end
          ACK_LO, ACK_WR: begin
            if (scl_fall) begin
              sda_low <= 1'b0;
              state   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt != 4'd7) begin
                shift   <= {shift[6:0], 1'b0};
                sda_low <= ~shift[6];
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                sda_low <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= RD_ACK;
              end
            end
          end
          RD_ACK: begin
            // Advance on the ACK-clock rise so rd_data_i has settled by the fall.
            if (scl_rise) begin
              ack_seen <= (sda_f == I2C_ACK);
              pointer  <= pointer + 16'd1;
            end else if (scl_fall) begin
              if (ack_seen) begin
                shift   <= rd_data_i;
                sda_low <= ~rd_data_i[7];
                state   <= RD_DATA;
              end else begin
                state <= IGNORE;
              end
            end
          end
          default: begin
            sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regport.sv
// Directed bench: bus-level controller tasks drive the target, a small register
// model answers reads, and every check is an immediate assertion.
module tb_i2c_target_regport;

  localparam int Q = 10;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_drv_low = 1'b0;
  logic        glitch = 1'b0;
  wire         sda;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;
  int tgt_low = 0;
  int busy_hi = 0;
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];

  pullup (sda);
  assign sda = sda_drv_low ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  i2c_target_regport dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .scl_i     (scl),
    .sda_io    (sda),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .busy_o    (busy)
  );

  always @(posedge clock) begin
    case (rd_addr)
      16'h0100: rd_data <= 8'hA5;
      16'h0101: rd_data <= 8'h3C;
      default:  rd_data <= 8'hEE;
    endcase
  end

  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      wr_a.push_back(wr_addr);
      wr_d.push_back(wr_data);
    end
    if (sda === 1'b0 && !sda_drv_low) tgt_low++;
    if (busy === 1'b1) busy_hi++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_start();
    tick(Q); sda_drv_low = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); sda_drv_low = 1'b1;
    tick(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_drv_low = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); sda_drv_low = 1'b0;
    tick(3 * Q);
  endtask

  task automatic send_bit(input logic b);
    tick(Q); sda_drv_low = ~b;
    tick(Q); scl = 1'b1;
    if (glitch && b) begin
      tick(Q); sda_drv_low = 1'b1;
      tick(1); sda_drv_low = 1'b0;
      tick(Q - 1);
    end else begin
      tick(2 * Q);
    end
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tick(Q); sda_drv_low = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); acked = (sda === 1'b0);
    tick(Q); scl = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic give_ack);
    logic [7:0] acc;
    acc = 8'h00;
    sda_drv_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(2 * Q); scl = 1'b1;
      tick(Q); acc = {acc[6:0], sda};
      tick(Q); scl = 1'b0;
    end
    d = acc;
    send_bit(~give_ack);
  endtask

  initial begin
    logic a0, a1, a2, a3, a4;
    logic [7:0] d0, d1;
    int base, base_low, base_busy;

    // Reset values
    tick(3);
    check("rst_sda", 32'(sda), 32'h1);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    tick(5);

    // Single-byte write
    base = wr_a.size();
    bus_start();
    send_byte(8'h6A, a0);
    check("t1_busy_after_ack", 32'(busy), 32'h1);
    send_byte(8'h30, a1);
    send_byte(8'h1A, a2);
    send_byte(8'h5C, a3);
    bus_stop();
    check("t1_acks", 32'({a0, a1, a2, a3}), 32'hF);
    check("t1_strobes", 32'(wr_a.size() - base), 32'd1);
    if (wr_a.size() > base) begin
      check("t1_wr_addr", 32'(wr_a[base]), 32'h301A);
      check("t1_wr_data", 32'(wr_d[base]), 32'h5C);
    end
    check("t1_pointer", 32'(rd_addr), 32'h301B);
    check("t1_busy_after_stop", 32'(busy), 32'h0);

    // Burst write across pointer wrap; SDA glitches on the high bits of 0x11
    base = wr_a.size();
    bus_start();
    send_byte(8'h6A, a0);
    send_byte(8'hFF, a1);
    send_byte(8'hFF, a2);
    glitch = 1'b1;
    send_byte(8'h11, a3);
    glitch = 1'b0;
    send_byte(8'h22, a4);
    bus_stop();
    check("t2_acks", 32'({a0, a1, a2, a3, a4}), 32'h1F);
    check("t2_strobes", 32'(wr_a.size() - base), 32'd2);
    if (wr_a.size() >= base + 2) begin
      check("t2_addr0", 32'(wr_a[base]), 32'hFFFF);
      check("t2_data0", 32'(wr_d[base]), 32'h11);
      check("t2_addr1", 32'(wr_a[base + 1]), 32'h0000);
      check("t2_data1", 32'(wr_d[base + 1]), 32'h22);
    end
    check("t2_pointer", 32'(rd_addr), 32'h0001);

    // Read with repeated START
    base = wr_a.size();
    bus_start();
    send_byte(8'h6A, a0);
    send_byte(8'h01, a1);
    send_byte(8'h00, a2);
    bus_start();
    send_byte(8'h6B, a3);
    recv_byte(d0, 1'b1);
    recv_byte(d1, 1'b0);
    bus_stop();
    check("t3_acks", 32'({a0, a1, a2, a3}), 32'hF);
    check("t3_rd0", 32'(d0), 32'hA5);
    check("t3_rd1", 32'(d1), 32'h3C);
    check("t3_no_strobe", 32'(wr_a.size() - base), 32'd0);
    check("t3_busy_idle", 32'(busy), 32'h0);
    check("t3_sda_released", 32'(sda), 32'h1);

    // Wrong device address
    base = wr_a.size();
    base_low = tgt_low;
    base_busy = busy_hi;
    bus_start();
    send_byte(8'h50, a0);
    send_byte(8'h12, a1);
    send_byte(8'h34, a2);
    send_byte(8'h56, a3);
    bus_stop();
    check("t4_acks", 32'({a0, a1, a2, a3}), 32'h0);
    check("t4_sda_pulled", 32'(tgt_low - base_low), 32'd0);
    check("t4_busy_cycles", 32'(busy_hi - base_busy), 32'd0);
    check("t4_no_strobe", 32'(wr_a.size() - base), 32'd0);

    // STOP after 5 data bits, then a normal transaction
    base = wr_a.size();
    bus_start();
    send_byte(8'h6A, a0);
    send_byte(8'h12, a1);
    send_byte(8'h34, a2);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus_stop();
    check("t5_no_strobe", 32'(wr_a.size() - base), 32'd0);
    check("t5_pointer", 32'(rd_addr), 32'h1234);
    bus_start();
    send_byte(8'h6A, a0);
    send_byte(8'h00, a1);
    send_byte(8'h05, a2);
    send_byte(8'h77, a3);
    bus_stop();
    check("t5_next_strobes", 32'(wr_a.size() - base), 32'd1);
    if (wr_a.size() > base) begin
      check("t5_next_addr", 32'(wr_a[base]), 32'h0005);
      check("t5_next_data", 32'(wr_d[base]), 32'h77);
    end

    // Reset while the target drives a 0 read bit (0x3C, bit 7 = 0)
    bus_start();
    send_byte(8'h6A, a0);
    send_byte(8'h01, a1);
    send_byte(8'h01, a2);
    bus_start();
    send_byte(8'h6B, a3);
    tick(Q);
    check("t6_driving_low", 32'(sda), 32'h0);
    check("t6_busy_pre", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_sda_released", 32'(sda), 32'h1);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_rd_addr", 32'(rd_addr), 32'h0);
    check("t6_wr_addr", 32'(wr_addr), 32'h0);
    check("t6_wr_data", 32'(wr_data), 32'h0);
    check("t6_wr_en", 32'(wr_en), 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(5);
    bus_stop();

    base = wr_a.size();
    bus_start();
    send_byte(8'h6A, a0);
    send_byte(8'hAB, a1);
    send_byte(8'hCD, a2);
    send_byte(8'h99, a3);
    bus_stop();
    check("t6_post_acks", 32'({a0, a1, a2, a3}), 32'hF);
    check("t6_post_strobes", 32'(wr_a.size() - base), 32'd1);
    if (wr_a.size() > base) begin
      check("t6_post_addr", 32'(wr_a[base]), 32'hABCD);
      check("t6_post_data", 32'(wr_d[base]), 32'h99);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
